// File: rtl/axi_vip_wr_arbiter.sv
// axi_vip_wr_arbiter: round-robin share of one AXI4-Lite write path (AW, W, B) among NUM_REQ requesters.
//   clk, rst_n                     clock and synchronous active-low reset
//   req_valid/addr/data/strb       packed per-requester write requests, requester i at slice i
//   req_ready                      one-hot accept, combinational, only while idle
//   rsp_valid, rsp_resp            one-cycle completion pulse to the owner plus its BRESP (held)
//   AW*/W*/B*                      AXI4-Lite write master channels, one write outstanding
//   AXI_VIP_WR_STATS_EN            adds wr_cnt (per-requester completions) and err_cnt (BRESP != OKAY)
module axi_vip_wr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ*AXI_DATA_WIDTH/8-1:0] req_strb,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [1:0]                          rsp_resp,
  output logic [AXI_ADDR_WIDTH-1:0]           AWADDR,
  output logic                                AWVALID,
  input  logic                                AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]           WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]         WSTRB,
  output logic                                WVALID,
  input  logic                                WREADY,
  input  logic [1:0]                          BRESP,
  input  logic                                BVALID,
  output logic                                BREADY
`ifdef AXI_VIP_WR_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]               wr_cnt,
  output logic [15:0]                         err_cnt
`endif
);
  localparam int SW = AXI_DATA_WIDTH / 8;
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
  state_t                    state_q;
  logic [IW-1:0]             ptr_q, owner_q, gnt_idx, cand;
  logic                      gnt_found;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]             wstrb_q;
  logic                      awvalid_q, wvalid_q, bready_q;
  logic [NUM_REQ-1:0]        rsp_valid_q;
  logic [1:0]                rsp_resp_q;
  // first valid requester at or above the pointer, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end
  assign req_ready = (state_q == IDLE && gnt_found) ? NUM_REQ'(1) << gnt_idx : '0;
  assign AWADDR    = awaddr_q;
  assign AWVALID   = awvalid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_resp  = rsp_resp_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: if (gnt_found) begin
          owner_q   <= gnt_idx;
          ptr_q     <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
          awaddr_q  <= req_addr[gnt_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
          wdata_q   <= req_data[gnt_idx*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
          wstrb_q   <= req_strb[gnt_idx*SW +: SW];
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          state_q   <= XFER;
        end
        XFER: begin
          if (AWREADY) awvalid_q <= 1'b0;
          if (WREADY) wvalid_q <= 1'b0;
          // a channel counts as done once its VALID is low or is handshaking now
          if ((!awvalid_q || AWREADY) && (!wvalid_q || WREADY)) begin
            bready_q <= 1'b1;
            state_q  <= RESP;
          end
        end
        RESP: if (BVALID) begin
          bready_q    <= 1'b0;
          rsp_valid_q <= NUM_REQ'(1) << owner_q;
          rsp_resp_q  <= BRESP;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef AXI_VIP_WR_STATS_EN
  logic [NUM_REQ*16-1:0] wr_cnt_q;
  logic [15:0]           err_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (state_q == RESP && BVALID) begin
      if (wr_cnt_q[owner_q*16 +: 16] != 16'hFFFF)
        wr_cnt_q[owner_q*16 +: 16] <= wr_cnt_q[owner_q*16 +: 16] + 16'd1;
      if (BRESP != 2'b00 && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end
  assign wr_cnt  = wr_cnt_q;
  assign err_cnt = err_cnt_q;
`endif
endmodule
